vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Parametrised VGA raster timing generator; successor to the fixed 640x480 counter.
- Porch, sync and active widths, sync polarity and counter width are all parameters.
- Adds a pixel clock-enable, synchronous restart, data-enable, blanking flags and line/frame start strobes.
- Position, sync and flag outputs are registered together so they describe the same pixel. Feeds the sprite/background renderers and the VGA pins.

Parameters:
- CW, 10, width of h/v counters and x/y outputs
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync width
- V_BP, 33, vertical back porch
- H_POL, 1, hsync active level (1 = active high)
- V_POL, 1, vsync active level

Ports:
- clk, in, 1, system clock
- rst_n, in, 1, asynchronous active-low reset
- pix_en, in, 1, pixel strobe; counters advance only when high
- sync_clr, in, 1, synchronous restart to pixel (0,0)
- hsync, out, 1, horizontal sync at H_POL level when active
- vsync, out, 1, vertical sync at V_POL level when active
- de, out, 1, high for visible pixels
- hblank, out, 1, high when x >= H_ACTIVE
- vblank, out, 1, high when y >= V_ACTIVE
- x_out, out, CW, horizontal position of the current output pixel
- y_out, out, CW, vertical position of the current output pixel
- line_start, out, 1, one-clk pulse when pixel (0,y) is presented
- frame_start, out, 1, one-clk pulse when pixel (0,0) is presented

Behaviour:
- Interface (decided): one clock, clk. Reset rst_n is asynchronous and active-low.
- Derived timing:
  - H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP.
  - hsync window is [H_ACTIVE + H_FP, H_ACTIVE + H_FP + H_SYNC - 1].
  - V_TOTAL and the vsync window are defined the same way.
  - Defaults give 800 x 525, hsync at 656..751, vsync at 490..491.
- Elaboration check: H_TOTAL and V_TOTAL must be <= 2^CW. All porch and sync widths must be >= 1. A violation is a $fatal.
- Counters h and v:
  - On clk with pix_en = 1: h increments. h wraps from H_TOTAL-1 to 0.
  - v increments only on an h wrap. v wraps from V_TOTAL-1 to 0.
  - With pix_en = 0, both counters hold.
- Output register:
  - On clk with pix_en = 1, x_out, y_out, de, hblank, vblank, hsync and vsync load from the pre-increment counter value (h, v).
  - Latency is one pix_en step. All of these outputs are mutually aligned. They hold while pix_en = 0.
- Strobes:
  - line_start = 1 for exactly one clk after a pix_en load of h = 0.
  - frame_start = 1 for exactly one clk after a pix_en load of h = 0 and v = 0.
  - Both strobes clear on the next clk regardless of pix_en.
- sync_clr:
  - On clk, h and v go to 0. sync_clr has priority over pix_en; a coincident pix_en step is dropped.
  - Output registers hold. Strobes clear.
  - The next pix_en presents (0,0) and fires frame_start.
- Reset (rst_n low, asynchronous), and on release:
  - h = v = 0, x_out = y_out = 0.
  - de = 0, hblank = vblank = 0, line_start = frame_start = 0.
  - hsync = ~H_POL, vsync = ~V_POL (inactive levels).
  - The first pix_en after release presents (0,0) with frame_start.
  - Reset mid-line behaves identically.
- Wrap boundary: pixel (H_TOTAL-1, V_TOTAL-1) is followed by (0,0) on the next pix_en. No skipped or duplicated pixel.
- Sync window checks are inclusive. Comparisons are unsigned at CW bits.

Decomposition:
- Package vga_timing_pkg holds:
  - default timing localparams for 640x480@60;
  - a vga_pos_t struct (x, y);
  - a function computing a derived total and sync window from porch widths.
- Sub-module vga_axis_counter (params CW, TOTAL; ports clk, rst_n, inc, clr, cnt, wrap), instantiated twice:
  - horizontal: inc = pix_en;
  - vertical: inc = pix_en & h_wrap.

Test Plan:
- Reset: rst_n low mid-frame -> outputs go immediately to x_out = 0, y_out = 0, de = 0, hsync = vsync = 0 (defaults), strobes 0. First pix_en after release -> frame_start = 1 for 1 clk, x_out = 0, y_out = 0.
- Full frame, pix_en = 1: 420000 cycles.
  - hsync high exactly at x_out 656..751 on every line.
  - vsync high at y_out 490..491.
  - de high for 307200 pixels.
  - frame_start period 420000 clk.
- pix_en toggling 1/0:
  - hsync period becomes 1600 clk; outputs hold on pix_en = 0 cycles.
  - line_start width stays 1 clk.
- Polarity: H_POL = 0, V_POL = 0 -> hsync low at x 656..751 and high elsewhere; reset value 1.
- sync_clr at (300,200) coincident with pix_en -> no advance that cycle. Next pix_en presents (0,0) with frame_start = 1.
- Tiny config: CW = 3, H_ACTIVE = 2, porches/sync = 1, V likewise -> totals 5 x 5. Walk 30 pix_en steps and check the wrap sequence 4 -> 0 on both axes.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: default 640x480@60 timing, position type and derived-window helper
package vga_timing_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
    } vga_pos_t;

    typedef struct packed {
        int unsigned total;
        int unsigned sync_start;
        int unsigned sync_end;
    } vga_axis_t;

    function automatic vga_axis_t axis_timing(int unsigned active, int unsigned fp,
                                              int unsigned sync, int unsigned bp);
        vga_axis_t t;
        t.total      = active + fp + sync + bp;
        t.sync_start = active + fp;
        t.sync_end   = active + fp + sync - 1;
        return t;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: wrapping position counter with synchronous clear priority over increment
module vga_axis_counter #(
    parameter int CW    = 10,
    parameter int TOTAL = 800
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc,
    input  logic          clr,
    output logic [CW-1:0] cnt,
    output logic          wrap
);

    assign wrap = (cnt == CW'(TOTAL - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc)
            cnt <= wrap ? '0 : cnt + 1'b1;
    end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing with registered, mutually aligned position/sync/flag outputs
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int CW       = 10,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit H_POL    = 1'b1,
    parameter bit V_POL    = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pix_en,
    input  logic          sync_clr,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic          hblank,
    output logic          vblank,
    output logic [CW-1:0] x_out,
    output logic [CW-1:0] y_out,
    output logic          line_start,
    output logic          frame_start
);

    localparam vga_axis_t HT = axis_timing(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam vga_axis_t VT = axis_timing(V_ACTIVE, V_FP, V_SYNC, V_BP);

    if (HT.total > 2**CW || VT.total > 2**CW || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_cfg
        $fatal(1, "vga_timing_gen: totals exceed counter range or a porch/sync width is zero");
    end

    logic [CW-1:0] h, v;
    logic          h_wrap, v_wrap_unused;
    logic          hs_on, vs_on, h_act, v_act;

    vga_axis_counter #(.CW(CW), .TOTAL(int'(HT.total))) u_hcnt (
        .clk(clk), .rst_n(rst_n), .inc(pix_en), .clr(sync_clr), .cnt(h), .wrap(h_wrap)
    );

    vga_axis_counter #(.CW(CW), .TOTAL(int'(VT.total))) u_vcnt (
        .clk(clk), .rst_n(rst_n), .inc(pix_en & h_wrap), .clr(sync_clr), .cnt(v),
        .wrap(v_wrap_unused)
    );

    always_comb begin
        hs_on = (h >= CW'(HT.sync_start)) && (h <= CW'(HT.sync_end));
        vs_on = (v >= CW'(VT.sync_start)) && (v <= CW'(VT.sync_end));
        h_act = h < CW'(H_ACTIVE);
        v_act = v < CW'(V_ACTIVE);
    end

    // sync_clr suppresses the load so the outputs keep showing the last presented pixel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_out       <= '0;
            y_out       <= '0;
            de          <= 1'b0;
            hblank      <= 1'b0;
            vblank      <= 1'b0;
            hsync       <= ~H_POL;
            vsync       <= ~V_POL;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            if (pix_en && !sync_clr) begin
                x_out       <= h;
                y_out       <= v;
                de          <= h_act && v_act;
                hblank      <= !h_act;
                vblank      <= !v_act;
                hsync       <= hs_on ? H_POL : ~H_POL;
                vsync       <= vs_on ? V_POL : ~V_POL;
                line_start  <= (h == '0);
                frame_start <= (h == '0) && (v == '0);
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboarded directed test on an 8x6 raster with active-low hsync
module tb_vga_timing_gen;

    // H: 4+1+2+1 = 8 (fills CW=3), hsync x 5..6 active low; V: 3+1+1+1 = 6, vsync y 4 active high
    localparam int CW = 3;

    typedef struct packed {
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        logic          de, hb, vb, hs, vs, ls, fs;
    } obs_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          pix_en = 1'b0;
    logic          sync_clr = 1'b0;
    logic          hsync, vsync, de, hblank, vblank, line_start, frame_start;
    logic [CW-1:0] x_out, y_out;

    obs_t q[$];
    obs_t e;
    int   mh, mv;
    int   total = 0;
    int   bad = 0;

    vga_timing_gen #(
        .CW(CW), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .H_POL(1'b0), .V_POL(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .sync_clr(sync_clr),
        .hsync(hsync), .vsync(vsync), .de(de), .hblank(hblank), .vblank(vblank),
        .x_out(x_out), .y_out(y_out), .line_start(line_start), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    function automatic obs_t reset_obs();
        obs_t r;
        r = '0;
        r.hs = 1'b1;
        return r;
    endfunction

    // Apply inputs, take one edge, advance the reference and queue what the DUT must show
    task automatic step(input logic pe, input logic clr, input logic rn);
        pix_en   = pe;
        sync_clr = clr;
        @(posedge clk);
        #1;
        if (!rst_n) begin
            e  = reset_obs();
            mh = 0;
            mv = 0;
        end else begin
            e.ls = 1'b0;
            e.fs = 1'b0;
            if (clr) begin
                mh = 0;
                mv = 0;
            end else if (pe) begin
                e.x  = CW'(mh);
                e.y  = CW'(mv);
                e.de = (mh < 4) && (mv < 3);
                e.hb = mh >= 4;
                e.vb = mv >= 3;
                e.hs = !(mh == 5 || mh == 6);
                e.vs = (mv == 4);
                e.ls = (mh == 0);
                e.fs = (mh == 0) && (mv == 0);
                if (mh == 7) begin
                    mh = 0;
                    mv = (mv == 5) ? 0 : mv + 1;
                end else begin
                    mh = mh + 1;
                end
            end
        end
        rst_n = rn;
        if (!rn) begin
            e  = reset_obs();
            mh = 0;
            mv = 0;
        end
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            obs_t exp_o, got;
            exp_o = q.pop_front();
            got   = '{x_out, y_out, de, hblank, vblank, hsync, vsync, line_start, frame_start};
            total++;
            if (got !== exp_o)
                begin
                bad++;
                $display("FAIL outputs t=%0t got x=%0d y=%0d de=%b hb=%b vb=%b hs=%b vs=%b ls=%b fs=%b required x=%0d y=%0d de=%b hb=%b vb=%b hs=%b vs=%b ls=%b fs=%b",
                         $time, got.x, got.y, got.de, got.hb, got.vb, got.hs, got.vs, got.ls, got.fs,
                         exp_o.x, exp_o.y, exp_o.de, exp_o.hb, exp_o.vb, exp_o.hs, exp_o.vs, exp_o.ls, exp_o.fs);
            end
        end
    end

    initial begin
        e  = reset_obs();
        mh = 0;
        mv = 0;
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        // two full frames plus wrap at full rate
        for (int i = 0; i < 100; i++) step(1'b1, 1'b0, 1'b1);
        // half-rate strobe: outputs hold and strobes last one clk
        for (int i = 0; i < 40; i++) step(i[0] == 1'b0, 1'b0, 1'b1);
        // restart coincident with a pixel step, then resume
        step(1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1'b1);
        // restart while idle
        step(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b1);
        // asynchronous reset mid-line, held across pixel steps
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 55; i++) step(1'b1, 1'b0, 1'b1);
        pix_en = 1'b0;
        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain queue left=%0d required 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
